permutation_sequencer: RTL and testbench
========================================

// Module: permutation_sequencer
// PURPOSE
//  Sequences the 25-bit line permutation datapath over a full 64-line state.
//  Accepts 64 input lines, drives ROUNDS passes of the datapath across all lines
//  (pulsing the line-register load), writes results back to an internal line
//  buffer, then drains the final 64 lines. Sits between the stimulus/host stream
//  and the Datapath, replacing the single-shot Controller for multi-round runs.
// PARAMETERS
//  LINE_W  25  width of one state line
//  LINES   64  lines per state; power of two, >=2
//  ADDR_W  6   log2(LINES)
//  ROUNDS  24  datapath passes per run; >=1
//  RND_W   5   width of round index; 2**RND_W >= ROUNDS
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       asynchronous, active-low reset
//  start      in   1       begin a run; sampled in IDLE only
//  in_valid   in   1       input line valid
//  in_line    in   LINE_W  input line
//  in_ready   out  1       high only in LOAD
//  dp_load    out  1       lineRegLoad to Datapath; 1-cycle pulse per line
//  dp_line    out  LINE_W  line presented to Datapath, valid while dp_load=1
//  dp_round   out  RND_W   current round index to Datapath
//  dp_result  in   LINE_W  Datapath newLine; valid 1 cycle after dp_load
//  out_valid  out  1       output line valid (DRAIN)
//  out_line   out  LINE_W  output line
//  out_ready  in   1       downstream accepts output line
//  busy       out  1       high in any state except IDLE
//  done       out  1       1-cycle pulse after last output line accepted
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; in_ready, dp_load, out_valid, busy, done=0;
//   dp_line, dp_round, out_line, line/round counters=0. Buffer not cleared.
//  States: IDLE -> LOAD -> ISSUE <-> CAPTURE -> DRAIN -> FIN -> IDLE.
//  IDLE: start=1 -> LOAD, line_cnt=0, busy=1 next cycle. start outside IDLE ignored.
//  LOAD: in_ready=1; each in_valid&in_ready writes buf[line_cnt], line_cnt++.
//   Write of line LINES-1 -> ISSUE, line_cnt=0, round=0. No timeout.
//  ISSUE: dp_load=1, dp_line=buf[line_cnt], dp_round=round; -> CAPTURE.
//  CAPTURE: buf[line_cnt]<=dp_result. If line_cnt!=LINES-1: line_cnt++, -> ISSUE.
//   Else line_cnt wraps to 0; if round!=ROUNDS-1: round++, -> ISSUE; else -> DRAIN.
//  Per line 2 cycles; compute phase exactly 2*LINES*ROUNDS cycles (3072 default).
//  DRAIN: out_valid=1, out_line=buf[line_cnt]; hold stable while out_ready=0.
//   out_valid&out_ready advances line_cnt; accept of line LINES-1 -> FIN.
//  FIN: done=1 for one cycle, busy=0 from next cycle; -> IDLE.
//  Buffer read is combinational or pre-fetched: out_line/dp_line valid in the
//   same cycle as out_valid/dp_load; no bubble between accepted output lines.
//  Counters wrap mod LINES; round never exceeds ROUNDS-1.
//  in_valid outside LOAD: ignored, no write. out_ready outside DRAIN: ignored.
//  Reset mid-run: immediate return to IDLE; partial state discarded, no done.
// CONFIGURATION
//  PERM_ABORT_EN defined: adds input port abort (1 bit). abort=1 in any non-IDLE
//   state -> IDLE next cycle, busy=0, no done, dp_load/out_valid/in_ready=0.
//   abort in IDLE ignored; abort and start same cycle in IDLE: start wins.
//  PERM_ABORT_EN undefined: no abort port; a run ends only via FIN or reset.
// TESTING
//  1 Reset: rst=0 mid-DRAIN -> all outputs 0 async, state IDLE, busy=0.
//  2 Identity datapath (dp_result=dp_line), ROUNDS=24, lines 0..63 = index ->
//    out_line k = k for k=0..63; done 1 cycle; busy 64+3072+64+1 cycles min.
//  3 Datapath model dp_result=dp_line+1, ROUNDS=24, all-zero input ->
//    every out_line = 25'd24; dp_load pulse count = 1536; dp_round 0..23.
//  4 Backpressure: out_ready toggled 1/0 every cycle -> out_line stable while
//    stalled, 64 lines in order, no duplicates, single done.
//  5 Ignore rules: start pulsed during ISSUE, in_valid=1 in DRAIN -> no restart,
//    buffer unchanged, output identical to scenario 2.
//  6 PERM_ABORT_EN: abort at round 5 -> IDLE next cycle, no done; new start
//    with fresh input -> correct full result as scenario 3.

Source files
------------

// File: rtl/permutation_sequencer.sv
// permutation_sequencer
//   Runs the 25-bit line permutation datapath over a full LINES-line state
//   for ROUNDS passes. Lines are loaded from the host stream into an
//   internal buffer. Each line is issued to the datapath, and its result is
//   written back in place. The final state is then drained to the
//   downstream port.
//
//   Optional feature: define PERM_ABORT_EN to add the `abort` input. It
//   drops any run in progress back to IDLE without raising done.
//
// Ports
//   clk, rst                 clock (rising edge), async active-low reset
//   start                    begin a run (sampled in IDLE only)
//   in_valid/in_line/in_ready   input line stream (ready only in LOAD)
//   dp_load/dp_line/dp_round    line issue to the datapath (1-cycle pulse)
//   dp_result                datapath result, valid 1 cycle after dp_load
//   out_valid/out_line/out_ready  output line stream (DRAIN)
//   busy                     high in every state except IDLE
//   done                     1-cycle pulse after the last line is accepted
//   abort                    (PERM_ABORT_EN only) cancel a run
module permutation_sequencer #(
  parameter int LINE_W = 25,
  parameter int LINES  = 64,
  parameter int ADDR_W = 6,
  parameter int ROUNDS = 24,
  parameter int RND_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
`ifdef PERM_ABORT_EN
  input  logic              abort,
`endif
  input  logic              in_valid,
  input  logic [LINE_W-1:0] in_line,
  output logic              in_ready,
  output logic              dp_load,
  output logic [LINE_W-1:0] dp_line,
  output logic [RND_W-1:0]  dp_round,
  input  logic [LINE_W-1:0] dp_result,
  output logic              out_valid,
  output logic [LINE_W-1:0] out_line,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ISSUE, S_CAPTURE, S_DRAIN, S_FIN
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] line_cnt;
  logic [RND_W-1:0]  round;
  logic [LINE_W-1:0] line_buf [LINES];

  logic              buf_we;
  logic [LINE_W-1:0] buf_wdata;
  logic              last_line, last_round, abort_req;

  assign last_line  = (line_cnt == ADDR_W'(LINES - 1));
  assign last_round = (round == RND_W'(ROUNDS - 1));
  assign dp_round   = round;

`ifdef PERM_ABORT_EN
  // abort has no effect in IDLE, so start always wins when both are seen there
  assign abort_req = abort && (state != S_IDLE);
`else
  assign abort_req = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Outputs are decoded from state. Because of that, they fall to zero the
  // moment the async reset forces the state to IDLE.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    dp_load   = 1'b0;
    dp_line   = '0;
    out_valid = 1'b0;
    out_line  = '0;
    busy      = 1'b1;
    done      = 1'b0;
    buf_we    = 1'b0;
    buf_wdata = '0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        in_ready  = 1'b1;
        buf_wdata = in_line;
        if (in_valid) begin
          buf_we = 1'b1;
          if (last_line) state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        dp_load   = 1'b1;
        dp_line   = line_buf[line_cnt];
        state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        buf_we    = 1'b1;
        buf_wdata = dp_result;
        if (last_line && last_round) state_nxt = S_DRAIN;
        else                         state_nxt = S_ISSUE;
      end
      S_DRAIN: begin
        // The buffer is read combinationally. This keeps the line aligned
        // with out_valid and lets lines go out back-to-back with no bubble.
        out_valid = 1'b1;
        out_line  = line_buf[line_cnt];
        if (out_ready && last_line) state_nxt = S_FIN;
      end
      S_FIN: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (abort_req) state_nxt = S_IDLE;
  end

  // line_cnt is ADDR_W wide and LINES == 2**ADDR_W. The +1 therefore wraps
  // mod LINES on its own, and the counter lands back on 0 at every phase
  // boundary.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      line_cnt <= '0;
      round    <= '0;
    end else if (abort_req) begin
      line_cnt <= '0;
      round    <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          line_cnt <= '0;
          round    <= '0;
        end
        S_LOAD:    if (in_valid) line_cnt <= line_cnt + 1'b1;
        S_CAPTURE: begin
          line_cnt <= line_cnt + 1'b1;
          if (last_line && !last_round) round <= round + 1'b1;
        end
        S_DRAIN:   if (out_ready) line_cnt <= line_cnt + 1'b1;
        S_FIN: begin
          line_cnt <= '0;
          round    <= '0;
        end
        default: ;
      endcase
    end
  end

  // Line storage is deliberately not reset; its contents are only
  // meaningful after a complete LOAD phase.
  always_ff @(posedge clk) begin
    if (buf_we) line_buf[line_cnt] <= buf_wdata;
  end

endmodule

// File: tb/tb_permutation_sequencer.sv
module tb_permutation_sequencer;
  localparam int LINE_W = 25;
  localparam int LINES  = 64;
  localparam int ADDR_W = 6;
  localparam int ROUNDS = 24;
  localparam int RND_W  = 5;

  typedef logic [LINE_W-1:0] lines_t [LINES];

  typedef struct {
    int mode;       // datapath function: 0 identity, 1 +1, 2 scramble
    int pat;        // input pattern: 0 index, 1 zero, 2 random
    int rdy;        // out_ready: 0 always, 1 toggle, 2 random
    bit gaps;       // random in_valid gaps during LOAD
    bit ign;        // stray start in ISSUE, stray in_valid in DRAIN
    int exp_loads;  // expected dp_load pulses
    int exp_busy;   // expected busy cycles, -1 = not exact
  } vec_t;

  logic clk = 1'b0;
  logic rst, start, in_valid, out_ready;
  logic [LINE_W-1:0] in_line, dp_result, dp_line, out_line;
  logic in_ready, dp_load, out_valid, busy, done;
  logic [RND_W-1:0] dp_round;
`ifdef PERM_ABORT_EN
  logic abort;
`endif

  int checks = 0;
  int errors = 0;
  int dp_mode = 0;

  permutation_sequencer #(
    .LINE_W(LINE_W), .LINES(LINES), .ADDR_W(ADDR_W),
    .ROUNDS(ROUNDS), .RND_W(RND_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
`ifdef PERM_ABORT_EN
    .abort(abort),
`endif
    .in_valid(in_valid), .in_line(in_line), .in_ready(in_ready),
    .dp_load(dp_load), .dp_line(dp_line), .dp_round(dp_round),
    .dp_result(dp_result),
    .out_valid(out_valid), .out_line(out_line), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [LINE_W-1:0] dp_f(input int m, input logic [LINE_W-1:0] x,
                                              input logic [RND_W-1:0] r);
    logic [LINE_W-1:0] t;
    case (m)
      0:       t = x;
      1:       t = x + 25'd1;
      default: begin
        t = x * 25'd5;
        t = (t ^ {20'd0, r}) + 25'd7;
      end
    endcase
    return t;
  endfunction

  // Datapath stand-in: result registered one cycle after the load pulse.
  always @(posedge clk) if (dp_load) dp_result <= dp_f(dp_mode, dp_line, dp_round);

  // Passive monitor; counters only ever grow, and tests compare deltas.
  int n_load = 0, n_done = 0, n_busy = 0, bad_round = 0;
  int round_loads [32];
  always @(negedge clk) begin
    if (dp_load) begin
      n_load++;
      if (int'(dp_round) >= ROUNDS) bad_round++;
      else round_loads[dp_round]++;
    end
    if (done) n_done++;
    if (busy) n_busy++;
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // At a negedge: pulse start, then stream all lines in.
  task automatic start_and_load(input lines_t din, input bit gaps);
    int k, cyc;
    bit fire;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    k = 0;
    cyc = 0;
    while (k < LINES && cyc < 2000) begin
      in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      in_line  = din[k];
      fire = in_valid && in_ready;
      @(negedge clk);
      if (fire) k++;
      cyc++;
    end
    in_valid = 1'b0;
    if (k < LINES) chk("load_timeout", k, LINES);
  endtask

  task automatic run_vec(input vec_t v, input int id);
    lines_t din, expv;
    logic [LINE_W-1:0] got[$];
    logic [LINE_W-1:0] val, prev_line;
    int b_load, b_done, b_busy, b_bad, cyc, pulses, stall_err, bad;
    int b_rl [32];
    bit prev_stall;
    for (int k = 0; k < LINES; k++) begin
      case (v.pat)
        0:       din[k] = LINE_W'(k);
        1:       din[k] = '0;
        default: din[k] = LINE_W'($urandom);
      endcase
      val = din[k];
      for (int r = 0; r < ROUNDS; r++) val = dp_f(v.mode, val, RND_W'(r));
      expv[k] = val;
    end
    dp_mode = v.mode;
    b_load = n_load; b_done = n_done; b_busy = n_busy; b_bad = bad_round;
    for (int r = 0; r < 32; r++) b_rl[r] = round_loads[r];

    start_and_load(din, v.gaps);

    cyc = 0; pulses = 0; stall_err = 0; prev_stall = 0; prev_line = '0;
    while (!done && cyc < 12000) begin
      case (v.rdy)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'(cyc & 1);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (v.ign) begin
        if (dp_load && pulses < 3) begin start = 1'b1; pulses++; end
        else start = 1'b0;
        in_valid = out_valid;
        in_line  = LINE_W'($urandom);
      end
      if (prev_stall && (!out_valid || out_line !== prev_line)) stall_err++;
      if (out_valid && out_ready) got.push_back(out_line);
      prev_stall = out_valid && !out_ready;
      prev_line  = out_line;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    if (cyc >= 12000) chk($sformatf("v%0d_done_timeout", id), 0, 1);
    @(negedge clk);
    @(negedge clk);

    chk($sformatf("v%0d_line_count", id), got.size(), LINES);
    bad = 0;
    for (int k = 0; k < LINES; k++) begin
      if (k >= got.size() || got[k] !== expv[k]) begin
        if (bad == 0)
          $display("FAIL v%0d_line[%0d]: got %0h expected %0h", id, k,
                   (k < got.size()) ? got[k] : '0, expv[k]);
        bad++;
      end
    end
    chk($sformatf("v%0d_lines_bad", id), bad, 0);
    chk($sformatf("v%0d_dp_loads", id), n_load - b_load, v.exp_loads);
    chk($sformatf("v%0d_done_pulses", id), n_done - b_done, 1);
    chk($sformatf("v%0d_busy_after", id), busy, 0);
    chk($sformatf("v%0d_stall_err", id), stall_err, 0);
    chk($sformatf("v%0d_bad_round", id), bad_round - b_bad, 0);
    bad = 0;
    for (int r = 0; r < ROUNDS; r++) if (round_loads[r] - b_rl[r] != LINES) bad++;
    chk($sformatf("v%0d_round_loads", id), bad, 0);
    if (v.exp_busy >= 0) chk($sformatf("v%0d_busy_cycles", id), n_busy - b_busy, v.exp_busy);
  endtask

  vec_t tv [5];

  initial begin
    lines_t idx, zer;
    int cyc, b_done;
    tv[0] = '{0, 0, 0, 1'b0, 1'b0, 1536, 3201};
    tv[1] = '{1, 1, 0, 1'b0, 1'b0, 1536, 3201};
    tv[2] = '{1, 1, 1, 1'b0, 1'b0, 1536, -1};
    tv[3] = '{2, 2, 2, 1'b1, 1'b0, 1536, -1};
    tv[4] = '{0, 0, 0, 1'b0, 1'b1, 1536, 3201};
    for (int k = 0; k < LINES; k++) begin idx[k] = LINE_W'(k); zer[k] = '0; end

    rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_line = '0; out_ready = 1'b0;
`ifdef PERM_ABORT_EN
    abort = 1'b0;
`endif
    #3;
    chk("rst_ctrl", {in_ready, dp_load, out_valid, busy, done}, 0);
    chk("rst_dp_line", dp_line, 0);
    chk("rst_dp_round", dp_round, 0);
    chk("rst_out_line", out_line, 0);
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    for (int i = 0; i < 5; i++) run_vec(tv[i], i);

    // Async reset in the middle of DRAIN.
    dp_mode = 0;
    start_and_load(idx, 1'b0);
    cyc = 0;
    while (!out_valid && cyc < 5000) begin @(negedge clk); cyc++; end
    chk("drain_reached", out_valid, 1);
    out_ready = 1'b1;
    repeat (10) @(negedge clk);
    b_done = n_done;
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_ctrl", {in_ready, dp_load, out_valid, busy, done}, 0);
    chk("mid_rst_out_line", out_line, 0);
    chk("mid_rst_dp_round", dp_round, 0);
    out_ready = 1'b0;
    @(negedge clk) rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("mid_rst_no_done", n_done - b_done, 0);
    chk("mid_rst_idle", busy, 0);
    run_vec(tv[0], 10);

`ifdef PERM_ABORT_EN
    dp_mode = 1;
    start_and_load(zer, 1'b0);
    cyc = 0;
    while (!(dp_load && dp_round == 5) && cyc < 5000) begin @(negedge clk); cyc++; end
    chk("abort_round5_reached", dp_round, 5);
    b_done = n_done;
    abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    chk("abort_ctrl", {in_ready, dp_load, out_valid, busy, done}, 0);
    repeat (4) @(negedge clk);
    chk("abort_no_done", n_done - b_done, 0);
    run_vec(tv[1], 11);
`else
    zer[0] = zer[1];
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
